// File: rtl/data_memory_pkg.sv
// Shared types and format helpers for the data memory controller.
package data_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] FMT_BYTE     = 2'b00;
  localparam logic [1:0] FMT_HALF     = 2'b01;
  localparam logic [1:0] FMT_WORD     = 2'b10;
  localparam logic [1:0] FMT_DOUBLE   = 2'b11;
  localparam int         FMT_UNSIGNED = 2;

  // Access size in bytes: 1, 2, 4 or 8.
  function automatic logic [3:0] size_of(input logic [2:0] fmt);
    return 4'd1 << fmt[1:0];
  endfunction

endpackage

// File: rtl/data_memory_controller_load_align_extend.sv
// Combinational load path: shift the two-beat read buffer down to the access
// offset, truncate to the access size and sign- or zero-extend.
module load_align_extend
  import data_memory_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]          buf_i,
  input  logic [$clog2(XLEN/8)-1:0]  offset_i,
  input  logic [2:0]                 fmt_i,
  output logic [XLEN-1:0]            data_o
);

  logic [XLEN-1:0] shifted;
  logic            is_unsigned;

  assign shifted     = XLEN'(buf_i >> {offset_i, 3'b000});
  assign is_unsigned = fmt_i[FMT_UNSIGNED];

  always_comb begin
    data_o = '0;
    unique case (fmt_i[1:0])
      FMT_BYTE: data_o = is_unsigned ? XLEN'(shifted[7:0])
                                     : XLEN'($signed(shifted[7:0]));
      FMT_HALF: data_o = is_unsigned ? XLEN'(shifted[15:0])
                                     : XLEN'($signed(shifted[15:0]));
      FMT_WORD: data_o = is_unsigned ? XLEN'(shifted[31:0])
                                     : XLEN'($signed(shifted[31:0]));
      default:  data_o = shifted;
    endcase
  end

endmodule

// File: rtl/data_memory_controller.sv
// Load/store front end: one request at a time, up to two bus beats per access,
// per-beat timeout. DATA_MEMORY_SPLIT_MISALIGNED_EN enables two-beat crossing accesses.
module data_memory_controller
  import data_memory_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_write_i,
  input  logic [2:0]          req_format_i,
  input  logic [31:0]         req_address_i,
  input  logic [XLEN-1:0]     req_write_data_i,
  output logic                resp_valid_o,
  output logic [XLEN-1:0]     resp_read_data_o,
  output logic                resp_error_o,
  output logic [31:0]         bus_address_o,
  output logic [XLEN-1:0]     bus_write_data_o,
  output logic [XLEN/8-1:0]   bus_byte_enable_o,
  output logic                bus_read_enable_o,
  output logic                bus_write_enable_o,
  input  logic                bus_ready_i,
  input  logic [XLEN-1:0]     bus_read_data_i
);

  localparam int BYTES = XLEN / 8;
  localparam int OW    = $clog2(BYTES);
`ifdef DATA_MEMORY_SPLIT_MISALIGNED_EN
  localparam int LANES = 2 * BYTES;
`else
  localparam int LANES = BYTES;
`endif
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_e              state_q;
  logic                req_ready_q, resp_valid_q, resp_error_q;
  logic [XLEN-1:0]     resp_read_data_q;
  logic [31:0]         bus_address_q;
  logic [XLEN-1:0]     bus_write_data_q;
  logic [BYTES-1:0]    bus_byte_enable_q;
  logic                bus_read_enable_q, bus_write_enable_q;
  logic [2:0]          fmt_q;
  logic [OW-1:0]       offset_q;
  logic                write_q;
  logic [CW-1:0]       cnt_q;
`ifdef DATA_MEMORY_SPLIT_MISALIGNED_EN
  logic                cross_q;
  logic [BYTES-1:0]    mask_hi_q;
  logic [XLEN-1:0]     wdata_hi_q;
  logic [XLEN-1:0]     rbuf_lo_q;
`endif

  logic [OW-1:0]       offset_d;
  logic [3:0]          size_d;
  logic [4:0]          end_d;
  logic                cross_d, illegal_d, reject_d;
  logic [LANES-1:0]    mask_d;
  logic [8*LANES-1:0]  wshift_d;
  logic [2*XLEN-1:0]   align_buf;
  logic [XLEN-1:0]     align_data;

  assign offset_d  = req_address_i[OW-1:0];
  assign size_d    = size_of(req_format_i);
  assign end_d     = 5'(offset_d) + 5'(size_d);
  assign cross_d   = end_d > 5'(BYTES);
  assign illegal_d = (req_format_i[1:0] == FMT_DOUBLE) && (XLEN == 32);
  assign mask_d    = ((LANES'(1) << size_d) - LANES'(1)) << offset_d;
  assign wshift_d  = (8*LANES)'(req_write_data_i) << {offset_d, 3'b000};
`ifdef DATA_MEMORY_SPLIT_MISALIGNED_EN
  assign reject_d  = illegal_d;
  assign align_buf = (state_q == ST_BEAT1) ? {bus_read_data_i, rbuf_lo_q}
                                           : {{XLEN{1'b0}}, bus_read_data_i};
`else
  assign reject_d  = illegal_d | cross_d;
  assign align_buf = {{XLEN{1'b0}}, bus_read_data_i};
`endif

  // Aligned load data is registered in the same edge that completes the last beat.
  load_align_extend #(.XLEN(XLEN)) u_align (
    .buf_i    (align_buf),
    .offset_i (offset_q),
    .fmt_i    (fmt_q),
    .data_o   (align_data)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q            <= ST_IDLE;
      req_ready_q        <= 1'b1;
      resp_valid_q       <= 1'b0;
      resp_error_q       <= 1'b0;
      resp_read_data_q   <= '0;
      bus_read_enable_q  <= 1'b0;
      bus_write_enable_q <= 1'b0;
      bus_byte_enable_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            req_ready_q       <= 1'b0;
            fmt_q             <= req_format_i;
            offset_q          <= offset_d;
            write_q           <= req_write_i;
            cnt_q             <= CW'(TIMEOUT_CYCLES);
            bus_address_q     <= {req_address_i[31:OW], {OW{1'b0}}};
            bus_byte_enable_q <= mask_d[BYTES-1:0];
            bus_write_data_q  <= wshift_d[XLEN-1:0];
`ifdef DATA_MEMORY_SPLIT_MISALIGNED_EN
            cross_q           <= cross_d;
            mask_hi_q         <= mask_d[LANES-1:BYTES];
            wdata_hi_q        <= wshift_d[8*LANES-1:XLEN];
`endif
            if (reject_d) begin
              state_q           <= ST_RESP;
              resp_valid_q      <= 1'b1;
              resp_error_q      <= 1'b1;
              bus_byte_enable_q <= '0;
            end else begin
              state_q            <= ST_BEAT0;
              bus_read_enable_q  <= ~req_write_i;
              bus_write_enable_q <= req_write_i;
            end
          end
        end
`ifdef DATA_MEMORY_SPLIT_MISALIGNED_EN
        ST_BEAT0, ST_BEAT1: begin
`else
        ST_BEAT0: begin
`endif
          if (bus_ready_i) begin
`ifdef DATA_MEMORY_SPLIT_MISALIGNED_EN
            if (state_q == ST_BEAT0 && cross_q) begin
              state_q           <= ST_BEAT1;
              rbuf_lo_q         <= bus_read_data_i;
              bus_address_q     <= bus_address_q + 32'(BYTES);
              bus_byte_enable_q <= mask_hi_q;
              bus_write_data_q  <= wdata_hi_q;
              cnt_q             <= CW'(TIMEOUT_CYCLES);
            end else
`endif
            begin
              state_q            <= ST_RESP;
              resp_valid_q       <= 1'b1;
              resp_read_data_q   <= write_q ? '0 : align_data;
              bus_read_enable_q  <= 1'b0;
              bus_write_enable_q <= 1'b0;
              bus_byte_enable_q  <= '0;
            end
          end else if (cnt_q == CW'(1)) begin
            state_q            <= ST_RESP;
            resp_valid_q       <= 1'b1;
            resp_error_q       <= 1'b1;
            bus_read_enable_q  <= 1'b0;
            bus_write_enable_q <= 1'b0;
            bus_byte_enable_q  <= '0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          state_q          <= ST_IDLE;
          req_ready_q      <= 1'b1;
          resp_valid_q     <= 1'b0;
          resp_error_q     <= 1'b0;
          resp_read_data_q <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o        = req_ready_q;
  assign resp_valid_o       = resp_valid_q;
  assign resp_error_o       = resp_error_q;
  assign resp_read_data_o   = resp_read_data_q;
  assign bus_address_o      = bus_address_q;
  assign bus_write_data_o   = bus_write_data_q;
  assign bus_byte_enable_o  = bus_byte_enable_q;
  assign bus_read_enable_o  = bus_read_enable_q;
  assign bus_write_enable_o = bus_write_enable_q;

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller (XLEN 32, timeout 8); expectations
// follow DATA_MEMORY_SPLIT_MISALIGNED_EN when it is defined for the build.
module tb_data_memory_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_format = 3'b000;
  logic [31:0] req_address = '0;
  logic [31:0] req_write_data = '0;
  logic        resp_valid;
  logic [31:0] resp_read_data;
  logic        resp_error;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_read_data = '0;

  data_memory_controller #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .clock_i            (clock),
    .reset_i            (reset),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_write_i        (req_write),
    .req_format_i       (req_format),
    .req_address_i      (req_address),
    .req_write_data_i   (req_write_data),
    .resp_valid_o       (resp_valid),
    .resp_read_data_o   (resp_read_data),
    .resp_error_o       (resp_error),
    .bus_address_o      (bus_address),
    .bus_write_data_o   (bus_write_data),
    .bus_byte_enable_o  (bus_byte_enable),
    .bus_read_enable_o  (bus_read_enable),
    .bus_write_enable_o (bus_write_enable),
    .bus_ready_i        (bus_ready),
    .bus_read_data_i    (bus_read_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clock) cyc++;

  // Bus responder configuration (written by the stimulus process only)
  logic [31:0] data_cfg [2];
  int          stall_cfg [2];

  // Responder / monitor state
  int          beat_idx = 0;
  int          stall_cnt = 0;
  logic [31:0] beat_addr [2];
  logic [3:0]  beat_be [2];
  logic [31:0] beat_wd [2];
  int          resp_cnt = 0;
  int          resp_cyc = 0;
  logic        resp_err_seen = 1'b0;
  logic [31:0] resp_data_seen = '0;
  int          en_cycles = 0;

  always @(negedge clock) begin
    if (resp_valid) begin
      resp_cnt++;
      resp_cyc = cyc;
      resp_err_seen = resp_error;
      resp_data_seen = resp_read_data;
    end
    if (bus_read_enable || bus_write_enable) begin
      en_cycles++;
      if (beat_idx < 2 && stall_cnt >= stall_cfg[beat_idx]) begin
        bus_ready = 1'b1;
        bus_read_data = data_cfg[beat_idx];
      end else begin
        bus_ready = 1'b0;
        stall_cnt++;
      end
    end else begin
      bus_ready = 1'b0;
    end
  end

  always @(posedge clock) begin
    if (reset || (req_valid && req_ready)) begin
      beat_idx = 0;
      stall_cnt = 0;
      for (int k = 0; k < 2; k++) begin
        beat_addr[k] = '0;
        beat_be[k] = '0;
        beat_wd[k] = '0;
      end
    end else if (bus_ready && (bus_read_enable || bus_write_enable) && beat_idx < 2) begin
      beat_addr[beat_idx] = bus_address;
      beat_be[beat_idx] = bus_byte_enable;
      beat_wd[beat_idx] = bus_write_data;
      beat_idx++;
      stall_cnt = 0;
    end
  end

  // One request through to its response; lat = response cycle - accept cycle.
  task automatic run_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] d0, input logic [31:0] d1,
                         input int s0, input int s1, output int lat, output int ens);
    int n, start, en0;
    data_cfg[0] = d0;
    data_cfg[1] = d1;
    stall_cfg[0] = s0;
    stall_cfg[1] = s1;
    @(posedge clock); #1;
    check_val("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_write = w;
    req_format = f;
    req_address = a;
    req_write_data = wd;
    n = cyc;
    start = resp_cnt;
    en0 = en_cycles;
    @(posedge clock); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 40 && resp_cnt == start; i++) @(posedge clock);
    if (resp_cnt == start) begin
      check_val("resp_wait", 0, 1);
      lat = -1;
    end else begin
      lat = resp_cyc - n;
    end
    @(posedge clock); #1;
    check_val("one_pulse", 64'(resp_cnt - start), 1);
    ens = en_cycles - en0;
  endtask

  int lat, ens, start;

  initial begin
    stall_cfg[0] = 0;
    stall_cfg[1] = 0;
    data_cfg[0] = '0;
    data_cfg[1] = '0;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_req_ready", req_ready, 1);
    check_val("rst_resp_valid", resp_valid, 0);
    check_val("rst_resp_error", resp_error, 0);
    check_val("rst_resp_data", resp_read_data, 0);
    check_val("rst_enables", {bus_read_enable, bus_write_enable}, 0);
    check_val("rst_byte_en", bus_byte_enable, 0);
    reset = 1'b0;

    // LW aligned
    run_req(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, lat, ens);
    check_val("lw_data", resp_data_seen, 32'hDEADBEEF);
    check_val("lw_err", resp_err_seen, 0);
    check_val("lw_lat", 64'(lat), 2);
    check_val("lw_be", beat_be[0], 4'b1111);
    check_val("lw_addr", beat_addr[0], 32'h100);

    // LB / LBU at lane 3
    run_req(0, 3'b000, 32'h103, 0, 32'h80000000, 0, 0, 0, lat, ens);
    check_val("lb_data", resp_data_seen, 32'hFFFFFF80);
    check_val("lb_be", beat_be[0], 4'b1000);
    run_req(0, 3'b100, 32'h103, 0, 32'h80000000, 0, 0, 0, lat, ens);
    check_val("lbu_data", resp_data_seen, 32'h00000080);

    // LH / LHU at offset 2
    run_req(0, 3'b001, 32'h102, 0, 32'h80010000, 0, 0, 0, lat, ens);
    check_val("lh_data", resp_data_seen, 32'hFFFF8001);
    run_req(0, 3'b101, 32'h102, 0, 32'h80010000, 0, 0, 0, lat, ens);
    check_val("lhu_data", resp_data_seen, 32'h00008001);

    // SB at offset 1
    run_req(1, 3'b000, 32'h201, 32'h000000A5, 0, 0, 0, 0, lat, ens);
    check_val("sb_be", beat_be[0], 4'b0010);
    check_val("sb_wd", beat_wd[0], 32'h0000A500);
    check_val("sb_addr", beat_addr[0], 32'h200);
    check_val("sb_lat", 64'(lat), 2);
    check_val("sb_data", resp_data_seen, 0);

    // SW crossing the word boundary
    run_req(1, 3'b010, 32'h102, 32'h11223344, 0, 0, 0, 0, lat, ens);
`ifdef DATA_MEMORY_SPLIT_MISALIGNED_EN
    check_val("sw_b0_addr", beat_addr[0], 32'h100);
    check_val("sw_b0_be", beat_be[0], 4'b1100);
    check_val("sw_b0_wd", beat_wd[0], 32'h33440000);
    check_val("sw_b1_addr", beat_addr[1], 32'h104);
    check_val("sw_b1_be", beat_be[1], 4'b0011);
    check_val("sw_b1_wd", beat_wd[1], 32'h00001122);
    check_val("sw_lat", 64'(lat), 3);
    check_val("sw_err", resp_err_seen, 0);
`else
    check_val("sw_err", resp_err_seen, 1);
    check_val("sw_lat", 64'(lat), 1);
    check_val("sw_no_bus", 64'(ens), 0);
`endif

    // LH crossing with 2 stalls on the second beat
    run_req(0, 3'b001, 32'h103, 0, 32'hAB000000, 32'h000000CD, 0, 2, lat, ens);
`ifdef DATA_MEMORY_SPLIT_MISALIGNED_EN
    check_val("lhx_data", resp_data_seen, 32'hFFFFCDAB);
    check_val("lhx_err", resp_err_seen, 0);
    check_val("lhx_lat", 64'(lat), 5);
    check_val("lhx_en_cycles", 64'(ens), 4);
`else
    check_val("lhx_err", resp_err_seen, 1);
    check_val("lhx_data", resp_data_seen, 0);
    check_val("lhx_lat", 64'(lat), 1);
    check_val("lhx_no_bus", 64'(ens), 0);
`endif

    // Timeout: bus never ready within the limit
    run_req(0, 3'b010, 32'h200, 0, 32'h55555555, 0, 30, 0, lat, ens);
    check_val("to_en_cycles", 64'(ens), 8);
    check_val("to_err", resp_err_seen, 1);
    check_val("to_data", resp_data_seen, 0);
    check_val("to_lat", 64'(lat), 9);

    // Stall exactly up to the limit: ready on the 8th cycle wins
    run_req(0, 3'b010, 32'h200, 0, 32'h0BADF00D, 0, 7, 0, lat, ens);
    check_val("edge_err", resp_err_seen, 0);
    check_val("edge_data", resp_data_seen, 32'h0BADF00D);
    check_val("edge_lat", 64'(lat), 9);

    // Illegal double on a 32-bit build
    run_req(0, 3'b011, 32'h100, 0, 32'h12345678, 0, 0, 0, lat, ens);
    check_val("ld_err", resp_err_seen, 1);
    check_val("ld_lat", 64'(lat), 1);
    check_val("ld_no_bus", 64'(ens), 0);

    // Reset in the middle of a transaction
    data_cfg[0] = 32'hAB000000;
    data_cfg[1] = 32'h000000CD;
`ifdef DATA_MEMORY_SPLIT_MISALIGNED_EN
    stall_cfg[0] = 0;
    stall_cfg[1] = 30;
`else
    stall_cfg[0] = 30;
    stall_cfg[1] = 0;
`endif
    @(posedge clock); #1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_format = 3'b001;
`ifdef DATA_MEMORY_SPLIT_MISALIGNED_EN
    req_address = 32'h103;
`else
    req_address = 32'h102;
`endif
    start = resp_cnt;
    @(posedge clock); #1;
    req_valid = 1'b0;
`ifdef DATA_MEMORY_SPLIT_MISALIGNED_EN
    for (int i = 0; i < 10 && beat_idx != 1; i++) @(posedge clock);
    #1;
`else
    @(posedge clock); #1;
`endif
    check_val("mid_beat_active", bus_read_enable, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_val("rst_mid_enables", {bus_read_enable, bus_write_enable}, 0);
    check_val("rst_mid_ready", req_ready, 1);
    repeat (12) @(posedge clock);
    #1;
    check_val("rst_mid_no_resp", 64'(resp_cnt - start), 0);

    run_req(0, 3'b010, 32'h100, 0, 32'h12345678, 0, 0, 0, lat, ens);
    check_val("post_rst_data", resp_data_seen, 32'h12345678);
    check_val("post_rst_err", resp_err_seen, 0);
    check_val("post_rst_lat", 64'(lat), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/data_memory_controller.md
Name: data_memory_controller

Overview:
- Sequential load/store unit front end between the pipeline memory stage and the data bus.
- Accepts one request at a time through a valid/ready handshake and drives a variable-latency bus with a bus_ready acknowledge.
- Supports XLEN-wide data paths and splits accesses that cross a bus word boundary into two bus beats.
- Merges, aligns and sign-extends load data, guards every beat with a timeout, and returns one response per request.

Parameters:
- XLEN, 32, data path width; only 32 or 64 are legal. BYTES = XLEN/8.
- TIMEOUT_CYCLES, 16, number of bus stall cycles before a beat is aborted; 0 disables the timeout.

Ports:
- clock  input  1  sole clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_write  input  1  1 = store, 0 = load
- req_format  input  3  [1:0] size: 00 byte, 01 half, 10 word, 11 double; [2] = 1 means unsigned load
- req_address  input  32  byte address
- req_write_data  input  XLEN  store data, LSB-aligned
- resp_valid  output  1  one-cycle response pulse
- resp_read_data  output  XLEN  aligned, extended load data (0 for stores and on error)
- resp_error  output  1  request failed (illegal format, misaligned access with split disabled, or timeout)
- bus_address  output  32  BYTES-aligned beat address
- bus_write_data  output  XLEN  store data shifted into byte lanes
- bus_byte_enable  output  BYTES  active lanes for the current beat
- bus_read_enable  output  1  load beat active
- bus_write_enable  output  1  store beat active
- bus_ready  input  1  beat completes in any cycle where an enable and bus_ready are both high
- bus_read_data  input  XLEN  lane-aligned read data, valid when bus_ready is high

Behaviour:
- States: IDLE, BEAT0, BEAT1, RESP.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_error 0, resp_read_data 0, both bus enables 0, bus_byte_enable 0. Reset mid-transaction abandons it with no response; the enables are low in the cycle after the reset edge.
- IDLE: req_ready = 1. If req_valid is high, latch the request.
  - Compute offset = address mod BYTES and size = 1 << fmt[1:0]; the access crosses a word boundary when offset + size > BYTES.
  - fmt 11 with XLEN = 32 is illegal: go to RESP with error and issue no bus beat.
  - Otherwise go to BEAT0.
- Outside IDLE, req_ready is 0.
- BEAT0: bus_address = address with its low log2(BYTES) bits cleared.
  - Lane mask = ((1 << size) - 1) << offset over 2*BYTES lanes. bus_byte_enable = the low BYTES lanes of the mask.
  - bus_write_data = data << (8*offset), low XLEN bits.
  - Outputs stay stable until bus_ready. On bus_ready, capture read data into the low half of a 2*XLEN buffer.
  - Next state: BEAT1 if the access crosses, else RESP.
- BEAT1: bus_address = beat0 address + BYTES; bus_byte_enable = the high BYTES lanes of the mask; bus_write_data = the high XLEN bits of the shifted data. On bus_ready, capture into the high half and go to RESP.
- Timeout: a per-beat counter clears on entry to each beat and increments on each stall cycle (enable high, bus_ready low).
  - When the count reaches TIMEOUT_CYCLES, drop the enable and go to RESP with error.
  - If bus_ready arrives in the same cycle the limit is reached, bus_ready wins.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
  - Load data = buffer >> (8*offset), truncated to size, then sign-extended unless fmt[2] = 1.
- Latency with a zero-wait bus: request accepted in cycle N, beat in N+1, response in N+2. A split access responds in N+3. Each stall cycle adds one.
- Back-to-back requests: a new request is accepted in the cycle after RESP at the earliest.

Optional Feature:
- Macro: DATA_MEMORY_SPLIT_MISALIGNED_EN.
- Defined: boundary-crossing accesses use two beats as described above.
- Undefined: a crossing access goes IDLE to RESP with resp_error = 1 and no bus activity, and the BEAT1 logic is not built.
- Accesses that do not cross a word boundary behave identically in both builds.

Decomposition:
- Shared package data_memory_pkg holds:
  - The state enum.
  - Format constants FMT_BYTE, FMT_HALF, FMT_WORD, FMT_DOUBLE and the FMT_UNSIGNED bit index.
  - Helper function size_of(fmt).
- One sub-module, load_align_extend: purely combinational 2*XLEN buffer shift, truncate and sign-extend, instantiated once for the RESP data path.

Test Plan (XLEN = 32, macro defined unless stated):
- LW at 0x100, bus_read_data 0xDEADBEEF, zero-wait: bus_byte_enable 1111, response 0xDEADBEEF in cycle N+2, resp_error 0.
- LB at 0x103, lane-aligned data 0x80000000: response 0xFFFFFF80. The same access with fmt[2] = 1 (LBU) returns 0x00000080.
- SW 0x11223344 at 0x102:
  - Beat0: address 0x100, byte enable 1100, write data 0x33440000.
  - Beat1: address 0x104, byte enable 0011, write data 0x00001122.
  - Response in N+3 with no error.
- LH at 0x103, beat0 data 0xAB000000, beat1 data 0x000000CD, 2 stall cycles on beat1: response 0xFFFFCDAB, no error.
- TIMEOUT_CYCLES = 8 with bus_ready held low: enable high for 8 cycles, then one resp_valid pulse with resp_error 1 and data 0. The same crossing LH with the macro undefined: resp_error 1 in N+1 and no bus enable ever raised.
- Reset asserted during BEAT1: enables low in the next cycle, req_ready 1, no resp_valid pulse. A following LW completes normally.
